lc3_pipeline_ctrl: RTL and testbench

Pipeline sequencer for the LC3 core. Generates the per-stage enables for fetch, decode, execute and writeback. Runs the data-memory access state machine for LD/LDR/LDI/ST/STR/STI, and stalls fetch across branches and jumps until they resolve in execute. It also raises ALU-result forwarding selects toward execute. It consumes the decoded instruction on the decode_out bus (IR) and the instruction currently held in execute (IR_Exec).

---
 rtl/lc3_pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_lc3_pipeline_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipeline_ctrl.sv
// LC3 pipeline sequencer: stage enables, data-memory access FSM, branch/jump
// fetch stall and ALU-result forwarding selects toward execute.
module lc3_pipeline_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_IND   = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_IDLE  = 2'd3
  } mem_state_t;

  typedef enum logic {
    CTL_RUN     = 1'b0,
    CTL_BR_WAIT = 1'b1
  } ctl_state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic       r_dec_valid;
  logic       r_exec_valid;
  mem_state_t r_mem_state;
  ctl_state_t r_ctl_state;

  logic [3:0] w_exec_op;
  logic [3:0] w_dec_op;
  logic [3:0] w_fetch_op;
  logic       w_mem_idle;
  logic       w_run;
  logic       w_exec_is_branch;
  logic       w_fetch_is_branch;
  logic       w_resolve;
  logic       w_cond_met;
  logic       w_producer;
  logic       w_dec_sr1_user;
  logic       w_dec_sr2_user;
  logic       w_unused_bits;

  assign w_exec_op  = IR_Exec[15:12];
  assign w_dec_op   = IR[15:12];
  assign w_fetch_op = IMem_dout[15:12];
  assign w_unused_bits = ^{IR[11:9], IR[4:3], IMem_dout[11:0], IR_Exec[8:0]};

  // Gating with reset keeps every enable low while reset is held, even though
  // the registered state already sits at its idle values.
  assign w_mem_idle = (r_mem_state == MEM_IDLE);
  assign w_run      = reset & w_mem_idle;

  assign w_exec_is_branch  = (w_exec_op == OP_BR) || (w_exec_op == OP_JMP);
  assign w_fetch_is_branch = (w_fetch_op == OP_BR) || (w_fetch_op == OP_JMP);
  assign w_resolve  = w_run && (r_ctl_state == CTL_BR_WAIT) && r_exec_valid && w_exec_is_branch;
  assign w_cond_met = |(IR_Exec[11:9] & psr);

  assign enable_fetch     = w_run & complete_instr & (r_ctl_state == CTL_RUN);
  assign enable_updatePC  = enable_fetch | w_resolve;
  assign enable_decode    = w_run;
  assign enable_execute   = w_run;
  assign enable_writeback = w_run;
  assign br_taken         = w_resolve & ((w_exec_op == OP_JMP) | w_cond_met);
  assign mem_state        = r_mem_state;

  // A producer is a valid ALU-class result in execute feeding a valid decode.
  assign w_producer = r_exec_valid && r_dec_valid &&
                      ((w_exec_op == OP_ADD) || (w_exec_op == OP_AND) ||
                       (w_exec_op == OP_NOT) || (w_exec_op == OP_LEA));
  assign w_dec_sr1_user = (w_dec_op == OP_ADD) || (w_dec_op == OP_AND) || (w_dec_op == OP_NOT);
  assign w_dec_sr2_user = ((w_dec_op == OP_ADD) || (w_dec_op == OP_AND)) && !IR[5];
  assign bypass_alu_1 = w_producer && w_dec_sr1_user && (IR_Exec[11:9] == IR[8:6]);
  assign bypass_alu_2 = w_producer && w_dec_sr2_user && (IR_Exec[11:9] == IR[2:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dec_valid  <= 1'b0;
      r_exec_valid <= 1'b0;
      r_mem_state  <= MEM_IDLE;
      r_ctl_state  <= CTL_RUN;
    end else begin
      r_dec_valid  <= enable_decode;
      r_exec_valid <= enable_execute;

      case (r_mem_state)
        MEM_IDLE: begin
          if (r_exec_valid) begin
            case (w_exec_op)
              OP_LD, OP_LDR:  r_mem_state <= MEM_READ;
              OP_LDI, OP_STI: r_mem_state <= MEM_IND;
              OP_ST, OP_STR:  r_mem_state <= MEM_WRITE;
              default:        r_mem_state <= MEM_IDLE;
            endcase
          end
        end
        MEM_IND: begin
          if (complete_data)
            r_mem_state <= (w_exec_op == OP_STI) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ, MEM_WRITE: begin
          if (complete_data) r_mem_state <= MEM_IDLE;
        end
        default: r_mem_state <= MEM_IDLE;
      endcase

      case (r_ctl_state)
        CTL_RUN:     if (enable_fetch && w_fetch_is_branch) r_ctl_state <= CTL_BR_WAIT;
        CTL_BR_WAIT: if (w_resolve) r_ctl_state <= CTL_RUN;
        default:     r_ctl_state <= CTL_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Bench for lc3_pipeline_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model built around a pending-phase queue.
module tb_lc3_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        complete_instr = 1'b0;
  logic        complete_data = 1'b0;
  logic [15:0] IMem_dout = 16'h5020;
  logic [15:0] IR = 16'h0000;
  logic [15:0] IR_Exec = 16'h5000;
  logic [2:0]  psr = 3'b000;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: pending memory phases, branch wait flag, stage valid flags.
  logic [1:0] exp_q[$];
  logic       m_wait_br, m_dec, m_exec;

  lc3_pipeline_ctrl dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr),
    .complete_data(complete_data), .IMem_dout(IMem_dout), .IR(IR), .IR_Exec(IR_Exec),
    .psr(psr), .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .mem_state(mem_state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    complete_instr = 1'b1;
    complete_data = 1'b0;
    IMem_dout = 16'h5020;
    IR = 16'h0000;
    IR_Exec = 16'h5000;
    psr = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
  endtask

  function automatic logic [4:0] all_en();
    return {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback};
  endfunction

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (all_en() !== 5'b11111) begin
      tests_failed++; $display("FAIL reset_first_cycle_en: got %b expected 11111", all_en());
    end
    complete_instr = 1'b0;
    settle();
    tests_run++;
    if ({enable_fetch, enable_decode} !== 2'b01) begin
      tests_failed++; $display("FAIL reset_fetch_follows_ci: got %b expected 01", {enable_fetch, enable_decode});
    end
    complete_instr = 1'b1;
    IR_Exec = 16'h6042;
    tick();
    tick();
    settle();
    tests_run++;
    if (mem_state !== 2'd0) begin
      tests_failed++; $display("FAIL reset_enter_read: got %0d expected 0", mem_state);
    end
    reset = 1'b0;
    settle();
    tests_run++;
    if ({mem_state, all_en(), br_taken, bypass_alu_1, bypass_alu_2} !== {2'd3, 5'b0, 3'b0}) begin
      tests_failed++;
      $display("FAIL reset_async_clear: got mem=%0d en=%b br=%b byp=%b%b expected mem=3 en=00000 br=0 byp=00",
               mem_state, all_en(), br_taken, bypass_alu_1, bypass_alu_2);
    end
    tick();
    IR_Exec = 16'h5000;
    reset = 1'b1;
    settle();
    tests_run++;
    if ({mem_state, enable_decode} !== {2'd3, 1'b1}) begin
      tests_failed++; $display("FAIL reset_release: got mem=%0d dec=%b expected mem=3 dec=1", mem_state, enable_decode);
    end
  endtask

  task automatic test_ldr();
    do_reset();
    IR_Exec = 16'h6042;
    tick();
    settle();
    tests_run++;
    if ({mem_state, enable_execute} !== {2'd3, 1'b1}) begin
      tests_failed++; $display("FAIL ldr_exec_cycle: got mem=%0d exe=%b expected mem=3 exe=1", mem_state, enable_execute);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      complete_data = (i == 3);
      settle();
      tests_run++;
      if (mem_state !== 2'd0) begin
        tests_failed++; $display("FAIL ldr_read_state[%0d]: got %0d expected 0", i, mem_state);
      end
      tests_run++;
      if (all_en() !== 5'b00000) begin
        tests_failed++; $display("FAIL ldr_stall_en[%0d]: got %b expected 00000", i, all_en());
      end
      tick();
    end
    complete_data = 1'b0;
    IR_Exec = 16'h5000;
    settle();
    tests_run++;
    if ({mem_state, enable_decode} !== {2'd3, 1'b1}) begin
      tests_failed++; $display("FAIL ldr_return_idle: got mem=%0d dec=%b expected mem=3 dec=1", mem_state, enable_decode);
    end
  endtask

  task automatic test_ldi();
    logic [1:0] seq [3];
    int stalls;
    seq[0] = 2'd1; seq[1] = 2'd0; seq[2] = 2'd3;
    stalls = 0;
    do_reset();
    complete_data = 1'b1;
    IR_Exec = 16'hA202;
    tick();
    settle();
    tests_run++;
    if (mem_state !== 2'd3) begin
      tests_failed++; $display("FAIL ldi_exec_cycle: got %0d expected 3", mem_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) IR_Exec = 16'h5000;
      settle();
      tests_run++;
      if (mem_state !== seq[i]) begin
        tests_failed++; $display("FAIL ldi_seq[%0d]: got %0d expected %0d", i, mem_state, seq[i]);
      end
      if (enable_decode === 1'b0) stalls++;
    end
    tests_run++;
    if (stalls != 2) begin
      tests_failed++; $display("FAIL ldi_stall_count: got %0d expected 2", stalls);
    end
    complete_data = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6];
    seq[0] = 2'd3; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd3; seq[5] = 2'd2;
    do_reset();
    complete_data = 1'b1;
    IR_Exec = 16'hB202;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) IR_Exec = 16'h3000;
      if (i == 5) IR_Exec = 16'h5000;
      IMem_dout = (mem_state != 2'd3) ? 16'h0000 : 16'h5020;
      settle();
      tests_run++;
      if (mem_state !== seq[i]) begin
        tests_failed++; $display("FAIL b2b_seq[%0d]: got %0d expected %0d", i, mem_state, seq[i]);
      end
      tick();
    end
    IMem_dout = 16'h5020;
    settle();
    tests_run++;
    if ({mem_state, enable_fetch} !== {2'd3, 1'b1}) begin
      tests_failed++; $display("FAIL b2b_branch_blocked: got mem=%0d fetch=%b expected mem=3 fetch=1", mem_state, enable_fetch);
    end
    complete_data = 1'b0;
  endtask

  task automatic test_branch();
    logic [15:0] instr [4];
    logic [2:0]  cc    [4];
    logic        taken [4];
    instr[0] = 16'h0A05; cc[0] = 3'b010; taken[0] = 1'b0;
    instr[1] = 16'h0A05; cc[1] = 3'b001; taken[1] = 1'b1;
    instr[2] = 16'h0A05; cc[2] = 3'b100; taken[2] = 1'b1;
    instr[3] = 16'hC1C0; cc[3] = 3'b000; taken[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      IMem_dout = instr[c];
      settle();
      tests_run++;
      if (enable_fetch !== 1'b1) begin
        tests_failed++; $display("FAIL br_fetch[%0d]: got %b expected 1", c, enable_fetch);
      end
      tick();
      IMem_dout = 16'h5020;
      for (int w = 0; w < 3; w++) begin
        settle();
        tests_run++;
        if ({enable_fetch, enable_updatePC, enable_decode, br_taken} !== 4'b0010) begin
          tests_failed++;
          $display("FAIL br_wait[%0d.%0d]: got fetch/upd/dec/br=%b expected 0010", c, w,
                   {enable_fetch, enable_updatePC, enable_decode, br_taken});
        end
        tick();
      end
      IR_Exec = instr[c];
      psr = cc[c];
      settle();
      tests_run++;
      if ({br_taken, enable_updatePC, enable_fetch} !== {taken[c], 2'b10}) begin
        tests_failed++;
        $display("FAIL br_resolve[%0d]: got br/upd/fetch=%b expected %b10", c,
                 {br_taken, enable_updatePC, enable_fetch}, taken[c]);
      end
      tick();
      IR_Exec = 16'h5000;
      settle();
      tests_run++;
      if ({enable_fetch, br_taken} !== 2'b10) begin
        tests_failed++; $display("FAIL br_after[%0d]: got fetch/br=%b expected 10", c, {enable_fetch, br_taken});
      end
    end
  endtask

  task automatic test_forwarding();
    logic [15:0] xi [6];
    logic [15:0] di [6];
    logic [1:0]  eb [6];
    xi[0] = 16'h1283; di[0] = 16'h1441; eb[0] = 2'b11;
    xi[1] = 16'h1283; di[1] = 16'h1461; eb[1] = 2'b10;
    xi[2] = 16'hE200; di[2] = 16'h1441; eb[2] = 2'b11;
    xi[3] = 16'h1283; di[3] = 16'h907F; eb[3] = 2'b10;
    xi[4] = 16'h1483; di[4] = 16'h1441; eb[4] = 2'b00;
    xi[5] = 16'h6283; di[5] = 16'h1441; eb[5] = 2'b00;
    do_reset();
    IR_Exec = 16'h1283;
    IR = 16'h1441;
    settle();
    tests_run++;
    if ({bypass_alu_1, bypass_alu_2} !== 2'b00) begin
      tests_failed++; $display("FAIL fwd_invalid: got %b expected 00", {bypass_alu_1, bypass_alu_2});
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      IR_Exec = xi[i];
      IR = di[i];
      settle();
      tests_run++;
      if ({bypass_alu_1, bypass_alu_2} !== eb[i]) begin
        tests_failed++; $display("FAIL fwd[%0d]: got %b expected %b", i, {bypass_alu_1, bypass_alu_2}, eb[i]);
      end
    end
  endtask

  task automatic test_imem_wait();
    do_reset();
    tick();
    complete_instr = 1'b0;
    IMem_dout = 16'h0000;
    settle();
    tests_run++;
    if (all_en() !== 5'b00111) begin
      tests_failed++; $display("FAIL imem_wait: got %b expected 00111", all_en());
    end
    tick();
    complete_instr = 1'b1;
    IMem_dout = 16'h5020;
    settle();
    tests_run++;
    if ({enable_fetch, enable_updatePC} !== 2'b11) begin
      tests_failed++; $display("FAIL imem_resume: got %b expected 11", {enable_fetch, enable_updatePC});
    end
  endtask

  function automatic logic [15:0] rand_instr(input logic [3:0] op);
    logic [15:0] v;
    v = 16'($urandom);
    v[15:12] = op;
    v[11:9] = 3'($urandom_range(0, 1));
    v[8:6]  = 3'($urandom_range(0, 1));
    v[2:0]  = 3'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic test_random();
    logic       idle, resolve, e_fetch, e_upd, e_br, producer, e_b1, e_b2;
    logic [1:0] e_mem;
    logic [3:0] xop, dop;
    do_reset();
    exp_q.delete();
    m_wait_br = 1'b0; m_dec = 1'b0; m_exec = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        reset = 1'b0;
        settle();
        tests_run++;
        if ({mem_state, all_en()} !== {2'd3, 5'b0}) begin
          tests_failed++; $display("FAIL rand_reset: got mem=%0d en=%b expected mem=3 en=00000", mem_state, all_en());
        end
        exp_q.delete();
        m_wait_br = 1'b0; m_dec = 1'b0; m_exec = 1'b0;
        reset = 1'b1;
      end
      complete_instr = ($urandom_range(0, 3) != 0);
      complete_data  = ($urandom_range(0, 2) == 0);
      psr = 3'($urandom);
      IMem_dout = ($urandom_range(0, 3) == 0) ? rand_instr($urandom_range(0, 1) ? 4'h0 : 4'hC)
                                              : rand_instr(4'($urandom));
      IR = rand_instr(4'($urandom));
      // The execute stage holds its instruction while a memory access is pending.
      if (exp_q.size() == 0) IR_Exec = rand_instr(4'($urandom));
      settle();

      idle = (exp_q.size() == 0);
      e_mem = idle ? 2'd3 : exp_q[0];
      xop = IR_Exec[15:12];
      dop = IR[15:12];
      resolve = m_wait_br && m_exec && idle && (xop == 4'h0 || xop == 4'hC);
      e_fetch = idle && complete_instr && !m_wait_br;
      e_upd = e_fetch || resolve;
      e_br = resolve && (xop == 4'hC || (IR_Exec[11:9] & psr) != 3'b000);
      producer = m_dec && m_exec && (xop inside {4'h1, 4'h5, 4'h9, 4'hE});
      e_b1 = producer && (dop inside {4'h1, 4'h5, 4'h9}) && IR_Exec[11:9] == IR[8:6];
      e_b2 = producer && (dop inside {4'h1, 4'h5}) && !IR[5] && IR_Exec[11:9] == IR[2:0];

      tests_run++;
      if (mem_state !== e_mem) begin
        tests_failed++; $display("FAIL rand_mem_state@%0d: got %0d expected %0d", cyc, mem_state, e_mem);
      end
      tests_run++;
      if (enable_fetch !== e_fetch) begin
        tests_failed++; $display("FAIL rand_fetch@%0d: got %b expected %b", cyc, enable_fetch, e_fetch);
      end
      tests_run++;
      if (enable_updatePC !== e_upd) begin
        tests_failed++; $display("FAIL rand_updpc@%0d: got %b expected %b", cyc, enable_updatePC, e_upd);
      end
      tests_run++;
      if ({enable_decode, enable_execute, enable_writeback} !== {3{idle}}) begin
        tests_failed++;
        $display("FAIL rand_stage_en@%0d: got %b expected %b", cyc,
                 {enable_decode, enable_execute, enable_writeback}, {3{idle}});
      end
      tests_run++;
      if (br_taken !== e_br) begin
        tests_failed++; $display("FAIL rand_br_taken@%0d: got %b expected %b", cyc, br_taken, e_br);
      end
      tests_run++;
      if ({bypass_alu_1, bypass_alu_2} !== {e_b1, e_b2}) begin
        tests_failed++;
        $display("FAIL rand_bypass@%0d: got %b expected %b", cyc, {bypass_alu_1, bypass_alu_2}, {e_b1, e_b2});
      end

      if (!idle) begin
        if (complete_data) void'(exp_q.pop_front());
      end else if (m_exec) begin
        case (xop)
          4'h2, 4'h6: exp_q.push_back(2'd0);
          4'h3, 4'h7: exp_q.push_back(2'd2);
          4'hA: begin exp_q.push_back(2'd1); exp_q.push_back(2'd0); end
          4'hB: begin exp_q.push_back(2'd1); exp_q.push_back(2'd2); end
          default: ;
        endcase
      end
      if (e_fetch && (IMem_dout[15:12] == 4'h0 || IMem_dout[15:12] == 4'hC)) m_wait_br = 1'b1;
      else if (resolve) m_wait_br = 1'b0;
      m_dec = idle;
      m_exec = idle;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_ldi();
    test_back_to_back();
    test_branch();
    test_forwarding();
    test_imem_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
